// File: rtl/max3_rr_sched.sv
// Round-robin scheduler sharing one 2-stage signed max-of-3 pipeline between two
// requesters, with a tagged result stream and per-requester completion counters.
module max3_rr_sched #(
    parameter int W     = 14,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req0_valid,
    input  logic signed [W-1:0] i_req0_a,
    input  logic signed [W-1:0] i_req0_b,
    input  logic signed [W-1:0] i_req0_c,
    output logic                o_req0_ready,
    input  logic                i_req1_valid,
    input  logic signed [W-1:0] i_req1_a,
    input  logic signed [W-1:0] i_req1_b,
    input  logic signed [W-1:0] i_req1_c,
    output logic                o_req1_ready,
    output logic                o_valid,
    output logic signed [W-1:0] o_max,
    output logic                o_id,
    input  logic                i_out_ready,
    output logic [CNT_W-1:0]    o_cnt0,
    output logic [CNT_W-1:0]    o_cnt1
);

    // Signed max of two; a tie returns the second operand.
    function automatic logic signed [W-1:0] f_max2(input logic signed [W-1:0] x,
                                                   input logic signed [W-1:0] y);
        return (x > y) ? x : y;
    endfunction

    logic                w_adv;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_acc;
    logic                w_xfer;
    logic signed [W-1:0] w_a;
    logic signed [W-1:0] w_b;
    logic signed [W-1:0] w_c;

    logic                r_rr_last;
    logic signed [W-1:0] r_ab_p1;
    logic signed [W-1:0] r_c_p1;
    logic                r_id_p1;
    logic                r_vld_p1;
    logic signed [W-1:0] r_max_p2;
    logic                r_id_p2;
    logic                r_vld_p2;
    logic [CNT_W-1:0]    r_cnt0;
    logic [CNT_W-1:0]    r_cnt1;

    // The whole pipe freezes only when a result is waiting and downstream refuses it.
    assign w_adv  = ~(r_vld_p2 & ~i_out_ready);
    assign w_gnt1 = i_req1_valid & (~i_req0_valid | ~r_rr_last);
    assign w_gnt0 = i_req0_valid & ~w_gnt1;

    assign o_req0_ready = w_adv & w_gnt0;
    assign o_req1_ready = w_adv & w_gnt1;
    assign w_acc        = o_req0_ready | o_req1_ready;
    assign w_xfer       = r_vld_p2 & i_out_ready;

    assign w_a = w_gnt1 ? i_req1_a : i_req0_a;
    assign w_b = w_gnt1 ? i_req1_b : i_req0_b;
    assign w_c = w_gnt1 ? i_req1_c : i_req0_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last <= 1'b1;
        end else if (w_acc) begin
            r_rr_last <= w_gnt1;
        end
    end

    // Stage 1: max(a,b) of the granted triple, c and tag carried alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ab_p1  <= '0;
            r_c_p1   <= '0;
            r_id_p1  <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else if (w_adv) begin
            r_ab_p1  <= f_max2(w_a, w_b);
            r_c_p1   <= w_c;
            r_id_p1  <= w_gnt1;
            r_vld_p1 <= w_acc;
        end
    end

    // Stage 2: final max, output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max_p2 <= '0;
            r_id_p2  <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else if (w_adv) begin
            r_max_p2 <= f_max2(r_ab_p1, r_c_p1);
            r_id_p2  <= r_id_p1;
            r_vld_p2 <= r_vld_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_xfer) begin
            if (r_id_p2) r_cnt1 <= r_cnt1 + CNT_W'(1);
            else         r_cnt0 <= r_cnt0 + CNT_W'(1);
        end
    end

    assign o_valid = r_vld_p2;
    assign o_max   = r_max_p2;
    assign o_id    = r_id_p2;
    assign o_cnt0  = r_cnt0;
    assign o_cnt1  = r_cnt1;

endmodule

// File: tb/tb_max3_rr_sched.sv
// Scoreboard bench for max3_rr_sched: a driver queues hand-computed results on each
// accepted triple, a negedge monitor pops and compares them and tracks the counters.
module tb_max3_rr_sched;
    localparam int W     = 14;
    localparam int CNT_W = 4;
    localparam int MASK  = (1 << CNT_W) - 1;

    typedef struct {
        int a;
        int b;
        int c;
        int mx;
    } vec_t;
    typedef struct {
        int mx;
        int id;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                i_req0_valid = 1'b0;
    logic signed [W-1:0] i_req0_a = '0, i_req0_b = '0, i_req0_c = '0;
    logic                o_req0_ready;
    logic                i_req1_valid = 1'b0;
    logic signed [W-1:0] i_req1_a = '0, i_req1_b = '0, i_req1_c = '0;
    logic                o_req1_ready;
    logic                o_valid;
    logic signed [W-1:0] o_max;
    logic                o_id;
    logic                i_out_ready = 1'b1;
    logic [CNT_W-1:0]    o_cnt0;
    logic [CNT_W-1:0]    o_cnt1;

    max3_rr_sched #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_req0_valid(i_req0_valid), .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
        .i_req0_c(i_req0_c), .o_req0_ready(o_req0_ready),
        .i_req1_valid(i_req1_valid), .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
        .i_req1_c(i_req1_c), .o_req1_ready(o_req1_ready),
        .o_valid(o_valid), .o_max(o_max), .o_id(o_id), .i_out_ready(i_out_ready),
        .o_cnt0(o_cnt0), .o_cnt1(o_cnt1)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    vec_t vecs[8];
    vec_t cur0, cur1;
    bit   acc0, acc1;
    bit   m_rr = 1'b1, m_s1v = 1'b0, m_ov = 1'b0;
    int   mc0 = 0, mc1 = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares the output stage against the queue head on every falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            mc0 = 0;
            mc1 = 0;
            chk("rst_o_valid", int'(o_valid), 0);
            chk("rst_o_max", int'(o_max), 0);
            chk("rst_o_id", int'(o_id), 0);
            chk("rst_o_cnt0", int'(o_cnt0), 0);
            chk("rst_o_cnt1", int'(o_cnt1), 0);
        end else begin
            chk("o_cnt0", int'(o_cnt0), mc0);
            chk("o_cnt1", int'(o_cnt1), mc1);
            if (o_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got max %0d id %0d, required no result",
                             o_max, o_id);
                end else begin
                    e = q[0];
                    chk("o_max", int'(o_max), e.mx);
                    chk("o_id", int'(o_id), e.id);
                    if (i_out_ready) begin
                        void'(q.pop_front());
                        if (e.id != 0) mc1 = (mc1 + 1) & MASK;
                        else           mc0 = (mc0 + 1) & MASK;
                    end
                end
            end
        end
    end

    // One cycle of stimulus: drive, check readies/o_valid against the model, step the model.
    task automatic step(input bit v0, input bit v1, input bit ordy);
        bit adv, g0, g1, er0, er1;
        exp_t e;
        i_req0_valid = v0;
        i_req0_a = cur0.a[W-1:0];
        i_req0_b = cur0.b[W-1:0];
        i_req0_c = cur0.c[W-1:0];
        i_req1_valid = v1;
        i_req1_a = cur1.a[W-1:0];
        i_req1_b = cur1.b[W-1:0];
        i_req1_c = cur1.c[W-1:0];
        i_out_ready = ordy;
        #1;
        chk("o_valid", int'(o_valid), int'(m_ov));
        adv = !(m_ov && !ordy);
        g1  = v1 && (!v0 || !m_rr);
        g0  = v0 && !g1;
        er0 = adv && g0;
        er1 = adv && g1;
        chk("ready0", int'(o_req0_ready), int'(er0));
        chk("ready1", int'(o_req1_ready), int'(er1));
        acc0 = er0;
        acc1 = er1;
        if (er0) begin
            e.mx = cur0.mx; e.id = 0; q.push_back(e); m_rr = 1'b0;
        end
        if (er1) begin
            e.mx = cur1.mx; e.id = 1; q.push_back(e); m_rr = 1'b1;
        end
        if (adv) begin
            m_ov  = m_s1v;
            m_s1v = er0 || er1;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            step(1'b0, 1'b0, 1'b1);
            n++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
            q.delete();
        end
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_o_valid", int'(o_valid), 0);
        chk("async_rst_o_cnt0", int'(o_cnt0), 0);
        chk("async_rst_o_cnt1", int'(o_cnt1), 0);
        m_rr = 1'b1; m_s1v = 1'b0; m_ov = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int i0, i1;
        vecs = '{'{5, -3, 2, 5}, '{-8192, 8191, 0, 8191}, '{-8192, -8192, -8192, -8192},
                 '{7, 7, 7, 7}, '{-1, -5, -2, -1}, '{100, -100, 200, 200},
                 '{3, 9, -4, 9}, '{-300, -301, -299, -299}};
        cur0 = vecs[0];
        cur1 = vecs[0];
        @(posedge clk);
        #2;
        rst = 1'b0;

        // req0 alone: (5,-3,2) -> 5, tag 0
        cur0 = vecs[0];
        step(1'b1, 1'b0, 1'b1);
        drain();

        // extremes through requester 1
        for (int i = 1; i <= 3; i++) begin
            cur1 = vecs[i];
            step(1'b0, 1'b1, 1'b1);
        end
        drain();

        // both requesting every cycle from reset: strict alternation starting at 0
        do_reset();
        i0 = 0;
        i1 = 4;
        for (int n = 0; n < 8; n++) begin
            cur0 = vecs[i0 % 8];
            cur1 = vecs[i1 % 8];
            step(1'b1, 1'b1, 1'b1);
            if (acc0) i0++;
            if (acc1) i1++;
        end
        drain();

        // full pipe stalled for 3 cycles, then released
        cur0 = vecs[5];
        step(1'b1, 1'b0, 1'b1);
        cur1 = vecs[6];
        step(1'b0, 1'b1, 1'b1);
        cur0 = vecs[7];
        cur1 = vecs[4];
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0);
        drain();

        // reset with two triples in flight, then requester 0 wins the first tie
        cur0 = vecs[1];
        cur1 = vecs[2];
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        do_reset();
        cur0 = vecs[3];
        cur1 = vecs[4];
        step(1'b1, 1'b1, 1'b1);
        chk("first_grant_after_rst", int'(acc0), 1);
        drain();

        // counter wrap: one req0 completion, then 16 req1 completions
        do_reset();
        cur0 = vecs[0];
        step(1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 16; n++) begin
            cur1 = vecs[n % 8];
            step(1'b0, 1'b1, 1'b1);
        end
        drain();
        chk("wrap_o_cnt1", int'(o_cnt1), 0);
        chk("wrap_o_cnt0", int'(o_cnt0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time %0t, required completion earlier", $time);
        $fatal(1);
    end

endmodule
